// File: rtl/stream_transpose_pkg.sv
// Shared types and helpers for the streaming transpose scheduler.
// State encodings, default geometry and the group one-hot helper.
package stream_transpose_pkg;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_GROUP = 4;
  localparam int MAX_GROUPS    = 64;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // One-hot select of the group holding index idx; caller truncates.
  function automatic logic [MAX_GROUPS-1:0] onehot_group(
    input int unsigned idx,
    input int unsigned group
  );
    return MAX_GROUPS'(1) << (idx / group);
  endfunction

endpackage

// File: rtl/stream_transpose_idx_counter.sv
// Mod-N row/column index counter with enable, clear and last flag.
// One instance tracks the write row, another the read column.
module stream_transpose_idx_counter
  import stream_transpose_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  assign idx  = idx_q;
  assign last = (idx_q == W'(N - 1));

  // Next index: clear wins, otherwise advance and wrap at N-1.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  // Index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/stream_transpose_scheduler.sv
// Ping-pong transpose buffer sequencer: N row beats in, N column beats out.
// Optional STREAM_TRANSPOSE_PERF_EN adds saturating stall counters.
module stream_transpose_scheduler
  import stream_transpose_pkg::*;
#(
  parameter  int N          = DEFAULT_N,
  parameter  int GROUP      = DEFAULT_GROUP,
  localparam int NUM_GROUPS = N / GROUP,
  localparam int W          = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  shift_down_enable,
  output logic                  shift_up_enable,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic [NUM_GROUPS-1:0] wr_group_sel,
  output logic [NUM_GROUPS-1:0] rd_group_sel,
  output logic                  in_last,
`ifdef STREAM_TRANSPOSE_PERF_EN
  output logic                  out_last,
  output logic [31:0]           stall_in_cnt,
  output logic [31:0]           stall_out_cnt
`else
  output logic                  out_last
`endif
);

  logic [W-1:0] wr_row;
  logic [W-1:0] rd_col;
  logic         wr_last;
  logic         rd_last;
  logic         flush;
  logic         fill_done;
  logic         drain_done;

  logic [1:0]   bank_full_q;
  logic [1:0]   bank_full_d;
  logic         wr_bank_q;
  logic         wr_bank_d;
  logic         rd_bank_q;
  logic         rd_bank_d;
  wr_state_e    wr_state_q;
  wr_state_e    wr_state_d;
  rd_state_e    rd_state_q;
  rd_state_e    rd_state_d;

  assign flush = clk_en & abort;

  // Handshakes come only from registered state, never the same-cycle drain.
  always_comb begin
    in_ready          = clk_en & ~abort & (wr_state_q == WR_FILL);
    out_valid         = clk_en & ~abort & (rd_state_q == RD_DRAIN);
    shift_down_enable = in_valid & in_ready;
    shift_up_enable   = out_valid & out_ready;
    fill_done         = shift_down_enable & wr_last;
    drain_done        = shift_up_enable & rd_last;
  end

  stream_transpose_idx_counter #(.N(N)) u_wr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (shift_down_enable),
    .clr     (flush),
    .idx     (wr_row),
    .last    (wr_last)
  );

  stream_transpose_idx_counter #(.N(N)) u_rd_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (shift_up_enable),
    .clr     (flush),
    .idx     (rd_col),
    .last    (rd_last)
  );

  // Bank flags, bank pointers and both side FSMs' next state.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    if (flush) begin
      bank_full_d = '0;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
    end else begin
      if (fill_done) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end
      if (drain_done) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
      end
    end
    wr_state_d = bank_full_d[wr_bank_d] ? WR_WAIT : WR_FILL;
    rd_state_d = bank_full_d[rd_bank_d] ? RD_DRAIN : RD_IDLE;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_state_q  <= WR_FILL;
      rd_state_q  <= RD_IDLE;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
    end
  end

  // Bank, group and last-beat indications for the datapath.
  always_comb begin
    wr_bank      = wr_bank_q;
    rd_bank      = rd_bank_q;
    wr_group_sel = NUM_GROUPS'(onehot_group(32'(wr_row), GROUP));
    rd_group_sel = NUM_GROUPS'(onehot_group(32'(rd_col), GROUP));
    in_last      = wr_last;
    out_last     = rd_last;
  end

`ifdef STREAM_TRANSPOSE_PERF_EN
  logic [31:0] stall_in_q;
  logic [31:0] stall_in_d;
  logic [31:0] stall_out_q;
  logic [31:0] stall_out_d;

  // Saturating stall counters, cleared by abort.
  always_comb begin
    stall_in_d  = stall_in_q;
    stall_out_d = stall_out_q;
    if (flush) begin
      stall_in_d  = '0;
      stall_out_d = '0;
    end else begin
      if (in_valid & ~in_ready & clk_en & ~&stall_in_q) begin
        stall_in_d = stall_in_q + 32'd1;
      end
      if (out_valid & ~out_ready & ~&stall_out_q) begin
        stall_out_d = stall_out_q + 32'd1;
      end
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_in_q  <= '0;
      stall_out_q <= '0;
    end else begin
      stall_in_q  <= stall_in_d;
      stall_out_q <= stall_out_d;
    end
  end

  assign stall_in_cnt  = stall_in_q;
  assign stall_out_cnt = stall_out_q;
`endif

endmodule
